// File: rtl/spike_rate_monitor_if.sv
// Bundle between the membrane-potential decoder side and the spike/rate monitor.
// The master drives potential and threshold; the slave publishes spikes and rate.
interface spike_rate_monitor_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] V_mem;
    logic [WIDTH-1:0] thresh;
    logic             spike;
    logic             in_refrac;
    logic [CNT_W-1:0] rate;
    logic             rate_valid;

    modport master (
        output V_mem,
        output thresh,
        input  spike,
        input  in_refrac,
        input  rate,
        input  rate_valid
    );

    modport slave (
        input  V_mem,
        input  thresh,
        output spike,
        output in_refrac,
        output rate,
        output rate_valid
    );
endinterface

// File: rtl/spike_rate_monitor.sv
// Threshold-crossing spike detector with refractory period and re-arm hysteresis,
// plus a fixed-window saturating spike-rate counter. All outputs are registered.
module spike_rate_monitor #(
    parameter int WIDTH  = 8,
    parameter int REFRAC = 4,
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spike_rate_monitor_if.slave  mon
);
    localparam int RC_W = (REFRAC > 1) ? $clog2(REFRAC) : 1;
    localparam int WC_W = $clog2(WINDOW);

    typedef enum logic [1:0] {
        ST_ARMED  = 2'b00,
        ST_REFRAC = 2'b01,
        ST_REARM  = 2'b10
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic [RC_W-1:0]   rcnt_r;
    logic              fire_s;
    logic              spike_s;
    logic              in_refrac_s;
    logic              spike_r;
    logic              in_refrac_r;
    logic [WC_W-1:0]   wcnt_r;
    logic [CNT_W-1:0]  scount_r;
    logic [CNT_W-1:0]  sum_s;
    logic [CNT_W-1:0]  rate_r;
    logic              rate_valid_r;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (v != {CNT_W{1'b1}})) begin
            r = v + CNT_W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign fire_s = (mon.V_mem >= mon.thresh);
    assign sum_s  = sat_inc(scount_r, spike_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= ST_ARMED;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic; REARM waits for a dip below threshold before re-arming.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_ARMED: begin
                if (fire_s) next_s = ST_REFRAC;
                else        next_s = ST_ARMED;
            end
            ST_REFRAC: begin
                if (rcnt_r == RC_W'(0)) next_s = ST_REARM;
                else                    next_s = ST_REFRAC;
            end
            ST_REARM: begin
                if (!fire_s) next_s = ST_ARMED;
                else         next_s = ST_REARM;
            end
            default: next_s = ST_ARMED;
        endcase
    end

    // Output decode, registered below so the pins never see comparator glitches.
    always_comb begin
        spike_s     = 1'b0;
        in_refrac_s = 1'b0;
        case (state_r)
            ST_ARMED:  spike_s     = fire_s;
            ST_REFRAC: in_refrac_s = 1'b1;
            ST_REARM:  spike_s     = 1'b0;
            default: begin
                spike_s     = 1'b0;
                in_refrac_s = 1'b0;
            end
        endcase
    end

    // Refractory down-counter, loaded on the firing edge.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rcnt_r <= RC_W'(0);
        end else if ((state_r == ST_ARMED) && fire_s) begin
            rcnt_r <= RC_W'(REFRAC - 1);
        end else if ((state_r == ST_REFRAC) && (rcnt_r != RC_W'(0))) begin
            rcnt_r <= rcnt_r - RC_W'(1);
        end else begin
            rcnt_r <= rcnt_r;
        end
    end

    // Registered spike and refractory flags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            spike_r     <= 1'b0;
            in_refrac_r <= 1'b0;
        end else begin
            spike_r     <= spike_s;
            in_refrac_r <= in_refrac_s;
        end
    end

    // Free-running window; a spike on the terminal cycle closes into the ending window.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wcnt_r       <= WC_W'(0);
            scount_r     <= {CNT_W{1'b0}};
            rate_r       <= {CNT_W{1'b0}};
            rate_valid_r <= 1'b0;
        end else if (wcnt_r == WC_W'(WINDOW - 1)) begin
            wcnt_r       <= WC_W'(0);
            scount_r     <= {CNT_W{1'b0}};
            rate_r       <= sum_s;
            rate_valid_r <= 1'b1;
        end else begin
            wcnt_r       <= wcnt_r + WC_W'(1);
            scount_r     <= sum_s;
            rate_r       <= rate_r;
            rate_valid_r <= 1'b0;
        end
    end

    assign mon.spike      = spike_r;
    assign mon.in_refrac  = in_refrac_r;
    assign mon.rate       = rate_r;
    assign mon.rate_valid = rate_valid_r;
endmodule

// File: tb/tb_spike_rate_monitor.sv
// Randomized phase-based bench for two monitor configurations against a
// cycle-timeline reference model (spike times, refractory windows, window sums).
module tb_spike_rate_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    spike_rate_monitor_if #(.WIDTH(8), .CNT_W(8)) if_a();
    spike_rate_monitor_if #(.WIDTH(8), .CNT_W(2)) if_b();

    spike_rate_monitor #(.WIDTH(8), .REFRAC(4), .WINDOW(16), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_a), .mon(if_a)
    );
    spike_rate_monitor #(.WIDTH(8), .REFRAC(1), .WINDOW(64), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_b), .mon(if_b)
    );

    int m_refrac[2] = '{4, 1};
    int m_window[2] = '{16, 64};
    int m_max[2]    = '{255, 3};

    int n_checks = 0;
    int n_errors = 0;
    int now = 0;

    // Reference model state: a timeline view, not an FSM.
    bit armed[2];
    int last_sp[2];
    int win_pos[2];
    int scnt[2];
    int e_sp[2];
    int e_ref[2];
    int e_rate[2];
    int e_rv[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, now, got, exp);
        end
    endtask

    // Predicts the outputs of the next cycle from this cycle's inputs.
    task automatic model_step(input int i, input bit rst, input int v, input int th);
        bit in_ref_now;
        int nxt_sp;
        int total;
        if (rst) begin
            armed[i] = 1'b1; last_sp[i] = -100; win_pos[i] = 0; scnt[i] = 0;
            e_sp[i] = 0; e_ref[i] = 0; e_rate[i] = 0; e_rv[i] = 0;
        end else begin
            in_ref_now = (now >= last_sp[i]) && (now < last_sp[i] + m_refrac[i]);
            nxt_sp = 0;
            if (armed[i] && (v >= th)) begin
                nxt_sp = 1;
                armed[i] = 1'b0;
            end else if (!armed[i] && !in_ref_now && (v < th)) begin
                armed[i] = 1'b1;
            end
            total = scnt[i] + e_sp[i];
            if (total > m_max[i]) total = m_max[i];
            if (win_pos[i] == m_window[i] - 1) begin
                e_rate[i] = total; e_rv[i] = 1; scnt[i] = 0; win_pos[i] = 0;
            end else begin
                scnt[i] = total; e_rv[i] = 0; win_pos[i] = win_pos[i] + 1;
            end
            e_ref[i] = in_ref_now ? 1 : 0;
            if (nxt_sp != 0) last_sp[i] = now + 1;
            e_sp[i] = nxt_sp;
        end
    endtask

    task automatic gen(input int mode, input int step, input int rr,
                       output int v, output int th, output bit rst);
        rst = 1'b0; th = 100; v = 0;
        case (mode)
            0: v = 0;
            1: v = (step == 5) ? 100 : 0;
            2: v = (step == 20) ? 50 : 150;
            3: v = (step % 2 == 1) ? 150 : 50;
            4: begin
                v = $urandom_range(80, 120);
                if ($urandom_range(0, 7) == 0) th = $urandom_range(90, 110);
            end
            5: begin th = 0; v = $urandom_range(0, 255); end
            6: begin v = (step % 2 == 1) ? 150 : 50; rst = (step == rr); end
            7: begin th = $urandom_range(0, 255); v = $urandom_range(0, 255); end
            8: rst = 1'b1;
            default: v = 0;
        endcase
    endtask

    int order[9] = '{8, 0, 1, 2, 3, 6, 5, 4, 7};

    initial begin
        int mode, len, v, th;
        int rr[2];
        bit rst;
        for (int i = 0; i < 2; i++) begin
            armed[i] = 1'b1; last_sp[i] = -100; win_pos[i] = 0; scnt[i] = 0;
            e_sp[i] = 0; e_ref[i] = 0; e_rate[i] = 0; e_rv[i] = 0;
        end
        rst_a = 1'b1; rst_b = 1'b1;
        if_a.V_mem = 8'd0; if_a.thresh = 8'd100;
        if_b.V_mem = 8'd0; if_b.thresh = 8'd100;
        @(posedge clk);
        for (int p = 0; p < 24; p++) begin
            mode = (p < 9) ? order[p] : $urandom_range(0, 7);
            len  = (p == 0) ? 3 : 48;
            rr[0] = $urandom_range(5, 30);
            rr[1] = $urandom_range(5, 30);
            for (int s = 0; s < len; s++) begin
                @(negedge clk);
                chk("a_spike",      {31'd0, if_a.spike},      e_sp[0]);
                chk("a_in_refrac",  {31'd0, if_a.in_refrac},  e_ref[0]);
                chk("a_rate",       {24'd0, if_a.rate},       e_rate[0]);
                chk("a_rate_valid", {31'd0, if_a.rate_valid}, e_rv[0]);
                chk("b_spike",      {31'd0, if_b.spike},      e_sp[1]);
                chk("b_in_refrac",  {31'd0, if_b.in_refrac},  e_ref[1]);
                chk("b_rate",       {30'd0, if_b.rate},       e_rate[1]);
                chk("b_rate_valid", {31'd0, if_b.rate_valid}, e_rv[1]);

                gen(mode, s, rr[0], v, th, rst);
                rst_a = rst; if_a.V_mem = 8'(v); if_a.thresh = 8'(th);
                model_step(0, rst, v, th);

                gen(mode, s, rr[1], v, th, rst);
                rst_b = rst; if_b.V_mem = 8'(v); if_b.thresh = 8'(th);
                model_step(1, rst, v, th);

                now++;
            end
        end
        @(negedge clk);
        chk("a_spike_end", {31'd0, if_a.spike}, e_sp[0]);
        chk("b_rate_end",  {30'd0, if_b.rate},  e_rate[1]);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
- Downstream of the membrane-potential decoder; consumes its 8-bit V_mem output.
- Detects threshold crossings and emits one-cycle spikes, with a refractory period and a re-arm hysteresis.
- Counts spikes over a fixed window of clock cycles and publishes a saturated spike rate for the uio/uo output mux.

Parameters:
- WIDTH, 8: width of V_mem and thresh.
- REFRAC, 4: refractory length in clock cycles. Legal range is REFRAC >= 1.
- WINDOW, 1000: rate window length in clock cycles. Legal range is WINDOW >= 2.
- CNT_W, 8: width of the spike counter and of rate.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-high, sampled on the rising clk edge. The top level drives it with the inverted pin reset, as for the decoder.
- V_mem  in  WIDTH  membrane potential from the decoder, unsigned.
- thresh  in  WIDTH  firing threshold, unsigned, sampled every cycle.
- spike  out  1  one-cycle spike pulse, registered.
- in_refrac  out  1  high while in the REFRAC state.
- rate  out  CNT_W  spike count of the last completed window.
- rate_valid  out  1  one-cycle pulse when rate is updated.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=ARMED; spike=0, in_refrac=0, rate=0, rate_valid=0.
  - Refractory counter, window counter wcnt and spike counter scount all cleared.
  - Reset overrides everything, including mid-refractory and mid-window; a partial window is discarded.
- Comparisons are unsigned: V_mem >= thresh means fire, V_mem < thresh means below.
- FSM has 3 states; all outputs are registered.
  - ARMED: if V_mem >= thresh at edge t, then spike=1 during cycle t+1, state goes to REFRAC, and the refractory counter loads REFRAC-1. Otherwise stay in ARMED with spike=0.
  - REFRAC: in_refrac=1; the comparator is ignored; the counter decrements each cycle. When the counter is 0, the next state is REARM. REFRAC lasts exactly REFRAC cycles, t+1 through t+REFRAC.
  - REARM: no spikes. If V_mem < thresh, go to ARMED next cycle; else stay in REARM. This is the hysteresis: V_mem sitting above thresh produces exactly one spike.
- Spike latency is 1 cycle from the sampling edge. Minimum spike spacing is REFRAC+2 cycles, reached when V_mem dips below thresh in the first REARM cycle.
- thresh=0: the first ARMED cycle fires, then the FSM stays in REARM forever, since V_mem < 0 is impossible. This is the required behaviour, not an error.
- thresh changing mid-refractory takes effect at the next REARM/ARMED comparison.
- Rate window:
  - wcnt counts 0..WINDOW-1 every cycle out of reset, independent of the FSM.
  - When wcnt != WINDOW-1: scount <= sat(scount + spike).
  - When wcnt == WINDOW-1: rate <= sat(scount + spike), scount <= 0, wcnt <= 0, and rate_valid=1 for the following cycle only.
  - sat() clamps at 2^CNT_W-1 and never wraps.
  - A spike on the terminal cycle counts toward the closing window, not the new one.
  - The first rate_valid occurs in cycle WINDOW, counting the first cycle after reset release as cycle 0. Later pulses occur every WINDOW cycles.
- rate holds its value between rate_valid pulses.

Test Plan:
All scenarios use REFRAC=4, WINDOW=16, CNT_W=8, thresh=100.
1. Reset and idle: hold rst_n=1 for 3 cycles, then release with V_mem=0. Required: spike=0 and in_refrac=0 throughout; rate_valid pulses in cycles 16, 32, ...; rate=0 each time.
2. Single crossing: V_mem=100 at cycle 5, 0 otherwise. Required: spike=1 only in cycle 6; in_refrac=1 in cycles 7–10; state back to ARMED by cycle 12.
3. Sustained above threshold: V_mem=150 constant from cycle 2. Required: exactly one spike, in cycle 3; the FSM stays in REARM. Then drop V_mem to 50 for 1 cycle and raise it back to 150: required is a second spike exactly 2 cycles after the dip.
4. Maximum rate: V_mem toggles 150/50 so each REARM exits immediately. Required: spike period of 6 cycles; rate=2 or 3 per 16-cycle window, matching a scoreboard count that includes terminal-cycle spikes.
5. Saturation: with CNT_W=2, REFRAC=1 and WINDOW=64, toggle V_mem. Required: rate=3, never wrapping to 0.
6. Reset mid-operation: assert rst_n during cycle 2 of REFRAC with scount=1. Required: next cycle has spike=0, in_refrac=0, rate=0; the window restarts, with the first rate_valid 16 cycles after release.
